// File: rtl/gpio_bus_master.sv
// gpio_bus_master: queues CPU-side register requests and replays them as
// single-cycle strobes on the GPIO IP bus, returning one response each.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for a queued request; pops and decodes the head
//   S_ISSUE | one-cycle bus strobe (gpio_en high)
//   S_WAIT  | counting down read latency before sampling gpio_out
//   S_RESP  | response held on rsp_* until rsp_ready
module gpio_bus_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          RD_LATENCY = 1,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_offset,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        gpio_en,
    output logic        write_enable,
    output logic [31:0] gpio_addr,
    output logic [31:0] gpio_in,
    input  logic [31:0] gpio_out,
    output logic [31:0] dir_shadow,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OFF_DATA = 4'h0;
    localparam logic [3:0] OFF_DIR  = 4'h4;
    localparam logic [3:0] OFF_READ = 4'h8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    // request FIFO
    logic             fifo_write  [FIFO_DEPTH];
    logic [3:0]       fifo_offset [FIFO_DEPTH];
    logic [31:0]      fifo_wdata  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             head_write;
    logic [3:0]       head_offset;
    logic [31:0]      head_wdata;

    // command registers for the request being executed
    logic        cmd_write,  cmd_write_nxt;
    logic [3:0]  cmd_offset, cmd_offset_nxt;
    logic [31:0] cmd_wdata,  cmd_wdata_nxt;
    logic [2:0]  lat_cnt,    lat_cnt_nxt;

    // next values of registered outputs
    logic        gpio_en_nxt;
    logic        write_enable_nxt;
    logic [31:0] gpio_addr_nxt;
    logic [31:0] gpio_in_nxt;
    logic        rsp_valid_nxt;
    logic        rsp_write_nxt;
    logic        rsp_err_nxt;
    logic [31:0] rsp_rdata_nxt;
    logic [31:0] dir_shadow_nxt;

    // READ is read-only; anything outside the three registers never reaches the bus
    function automatic logic req_legal(input logic wr, input logic [3:0] off);
        logic ok;
        case (off)
            OFF_DATA, OFF_DIR: ok = 1'b1;
            OFF_READ:          ok = !wr;
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign empty       = (count == '0);
    // ready comes only from the registered count, so a pop never re-opens it in the same cycle
    assign req_ready   = !full;
    assign push        = req_valid && req_ready;
    assign head_write  = fifo_write[rd_ptr];
    assign head_offset = fifo_offset[rd_ptr];
    assign head_wdata  = fifo_wdata[rd_ptr];
    assign busy        = (state != S_IDLE) || !empty;

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_write[i]  <= 1'b0;
                fifo_offset[i] <= '0;
                fifo_wdata[i]  <= '0;
            end
        end else begin
            if (push) begin
                fifo_write[wr_ptr]  <= req_write;
                fifo_offset[wr_ptr] <= req_offset;
                fifo_wdata[wr_ptr]  <= req_wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state, command registers and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cmd_write    <= 1'b0;
            cmd_offset   <= '0;
            cmd_wdata    <= '0;
            lat_cnt      <= '0;
            gpio_en      <= 1'b0;
            write_enable <= 1'b0;
            gpio_addr    <= '0;
            gpio_in      <= '0;
            rsp_valid    <= 1'b0;
            rsp_write    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            dir_shadow   <= '0;
        end else begin
            state        <= state_nxt;
            cmd_write    <= cmd_write_nxt;
            cmd_offset   <= cmd_offset_nxt;
            cmd_wdata    <= cmd_wdata_nxt;
            lat_cnt      <= lat_cnt_nxt;
            gpio_en      <= gpio_en_nxt;
            write_enable <= write_enable_nxt;
            gpio_addr    <= gpio_addr_nxt;
            gpio_in      <= gpio_in_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_write    <= rsp_write_nxt;
            rsp_err      <= rsp_err_nxt;
            rsp_rdata    <= rsp_rdata_nxt;
            dir_shadow   <= dir_shadow_nxt;
        end
    end

    // next-state and next-output decode; bus outputs default to 0 so they are high only in S_ISSUE
    always_comb begin
        state_nxt        = state;
        pop              = 1'b0;
        cmd_write_nxt    = cmd_write;
        cmd_offset_nxt   = cmd_offset;
        cmd_wdata_nxt    = cmd_wdata;
        lat_cnt_nxt      = lat_cnt;
        gpio_en_nxt      = 1'b0;
        write_enable_nxt = 1'b0;
        gpio_addr_nxt    = '0;
        gpio_in_nxt      = '0;
        rsp_valid_nxt    = rsp_valid;
        rsp_write_nxt    = rsp_write;
        rsp_err_nxt      = rsp_err;
        rsp_rdata_nxt    = rsp_rdata;
        dir_shadow_nxt   = dir_shadow;

        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop            = 1'b1;
                    cmd_write_nxt  = head_write;
                    cmd_offset_nxt = head_offset;
                    cmd_wdata_nxt  = head_wdata;
                    if (req_legal(head_write, head_offset)) begin
                        state_nxt        = S_ISSUE;
                        gpio_en_nxt      = 1'b1;
                        write_enable_nxt = head_write;
                        gpio_addr_nxt    = BASE_ADDR + {28'h0, head_offset};
                        gpio_in_nxt      = head_write ? head_wdata : 32'h0;
                    end else begin
                        state_nxt     = S_RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_write_nxt = head_write;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_write) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = '0;
                    if (cmd_offset == OFF_DIR) begin
                        dir_shadow_nxt = cmd_wdata;
                    end
                end else begin
                    state_nxt   = S_WAIT;
                    lat_cnt_nxt = 3'(RD_LATENCY);
                end
            end
            S_WAIT: begin
                lat_cnt_nxt = lat_cnt - 1'b1;
                // count of 1 marks the last latency cycle, when gpio_out is valid
                if (lat_cnt == 3'd1) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = 1'b0;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = gpio_out;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt     = S_IDLE;
                    rsp_valid_nxt = 1'b0;
                    rsp_write_nxt = 1'b0;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Testbench for gpio_bus_master: two instances (read latency 1 and 3), each
// with its own GPIO IP model, share the request stimulus through a selector.
module tb_gpio_bus_master;

    localparam logic [31:0] BASE = 32'h2000_0000;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
    } stb_t;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [31:0] data;
        logic        dir_upd;
        logic [31:0] dirval;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [3:0]  req_offset;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic [31:0] pins;
    logic        mon_on;
    logic        rand_rdy;

    logic [1:0]       d_req_valid, d_req_ready, d_rsp_valid, d_rsp_write, d_rsp_err;
    logic [1:0]       d_gpio_en, d_write_enable, d_busy;
    logic [1:0][31:0] d_rsp_rdata, d_gpio_addr, d_gpio_in, d_gpio_out, d_dir_shadow;

    logic        req_ready, rsp_valid, rsp_write, rsp_err, gpio_en, write_enable, busy;
    logic [31:0] rsp_rdata, gpio_addr, gpio_in, dir_shadow;

    int n_chk = 0;
    int n_pass = 0;
    int n_stb = 0;
    int n_rsp = 0;
    int cyc = 0;

    stb_t exp_stb[$];
    rsp_t exp_rsp[$];
    int   stb_cyc[$];
    int   rsp_cyc[$];
    logic [31:0] ref_data [2];
    logic [31:0] ref_dir  [2];
    logic [31:0] exp_dir  [2];

    logic        st_wr  [4];
    logic [3:0]  st_off [4];
    logic [31:0] st_wd  [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign req_ready    = d_req_ready[sel];
    assign rsp_valid    = d_rsp_valid[sel];
    assign rsp_write    = d_rsp_write[sel];
    assign rsp_err      = d_rsp_err[sel];
    assign rsp_rdata    = d_rsp_rdata[sel];
    assign gpio_en      = d_gpio_en[sel];
    assign write_enable = d_write_enable[sel];
    assign gpio_addr    = d_gpio_addr[sel];
    assign gpio_in      = d_gpio_in[sel];
    assign dir_shadow   = d_dir_shadow[sel];
    assign busy         = d_busy[sel];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] ip_data = '0;
        logic [31:0] ip_dir  = '0;
        logic [31:0] rd_val;
        logic [7:0]  pv = '0;
        logic [31:0] pd [8];

        assign d_req_valid[g] = req_valid && (int'(sel) == g);

        gpio_bus_master #(
            .BASE_ADDR (BASE),
            .RD_LATENCY(LAT),
            .FIFO_DEPTH(2)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_valid   (d_req_valid[g]),
            .req_ready   (d_req_ready[g]),
            .req_write   (req_write),
            .req_offset  (req_offset),
            .req_wdata   (req_wdata),
            .rsp_valid   (d_rsp_valid[g]),
            .rsp_ready   (rsp_ready),
            .rsp_write   (d_rsp_write[g]),
            .rsp_err     (d_rsp_err[g]),
            .rsp_rdata   (d_rsp_rdata[g]),
            .gpio_en     (d_gpio_en[g]),
            .write_enable(d_write_enable[g]),
            .gpio_addr   (d_gpio_addr[g]),
            .gpio_in     (d_gpio_in[g]),
            .gpio_out    (d_gpio_out[g]),
            .dir_shadow  (d_dir_shadow[g]),
            .busy        (d_busy[g])
        );

        // IP register decode for reads
        always_comb begin
            if (d_gpio_addr[g] == BASE)               rd_val = ip_data;
            else if (d_gpio_addr[g] == BASE + 32'h4)  rd_val = ip_dir;
            else if (d_gpio_addr[g] == BASE + 32'h8)  rd_val = pins;
            else                                      rd_val = 32'hEEEE_EEEE;
        end

        // IP model: register writes and a read pipeline valid only in cycle T+LAT
        always @(posedge clk) begin
            pv    <= {pv[6:0], d_gpio_en[g] & ~d_write_enable[g]};
            pd[0] <= rd_val;
            for (int k = 1; k < 8; k++) pd[k] <= pd[k-1];
            if (d_gpio_en[g] && d_write_enable[g]) begin
                if (d_gpio_addr[g] == BASE)              ip_data <= d_gpio_in[g];
                else if (d_gpio_addr[g] == BASE + 32'h4) ip_dir  <= d_gpio_in[g];
            end
        end

        assign d_gpio_out[g] = pv[LAT-1] ? pd[LAT-1] : (32'h0BAD_0000 ^ 32'(cyc));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // reference model: what each accepted request must do on the bus and answer
    task automatic model_accept(input logic wr, input logic [3:0] off, input logic [31:0] wd);
        rsp_t r;
        stb_t s;
        logic ok;
        ok = (off == 4'h0) || (off == 4'h4) || (off == 4'h8 && !wr);
        r = '0;
        r.wr = wr;
        if (!ok) begin
            r.err = 1'b1;
        end else begin
            s.wr   = wr;
            s.addr = BASE + 32'(off);
            s.din  = wr ? wd : 32'h0;
            exp_stb.push_back(s);
            if (wr) begin
                if (off == 4'h0) ref_data[sel] = wd;
                else begin
                    ref_dir[sel] = wd;
                    r.dir_upd    = 1'b1;
                    r.dirval     = wd;
                end
            end else begin
                r.data = (off == 4'h0) ? ref_data[sel] : (off == 4'h4) ? ref_dir[sel] : pins;
            end
        end
        exp_rsp.push_back(r);
    endtask

    // bus / response monitor
    always @(negedge clk) begin
        stb_t s;
        rsp_t r;
        if (mon_on) begin
            if (gpio_en) begin
                if (exp_stb.size() == 0) begin
                    check("stb_unexpected", gpio_en, 1'b0);
                end else begin
                    s = exp_stb.pop_front();
                    check("stb_we", write_enable, s.wr);
                    check("stb_addr", gpio_addr, s.addr);
                    check("stb_din", gpio_in, s.din);
                    stb_cyc.push_back(cyc);
                    n_stb++;
                end
            end else begin
                check("idle_we_addr", {write_enable, gpio_addr}, '0);
                check("idle_din", gpio_in, '0);
            end
            if (req_valid && req_ready) model_accept(req_write, req_offset, req_wdata);
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_write", rsp_write, r.wr);
                    check("rsp_err", rsp_err, r.err);
                    check("rsp_rdata", rsp_rdata, r.data);
                    if (r.dir_upd) exp_dir[sel] = r.dirval;
                    check("dir_shadow", dir_shadow, exp_dir[sel]);
                    rsp_cyc.push_back(cyc);
                    n_rsp++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push(input logic wr, input logic [3:0] off, input logic [31:0] wd);
        bit done = 1'b0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_offset = off;
        req_wdata  = wd;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic drain(input int max_cyc);
        int t = 0;
        while ((exp_rsp.size() != 0 || busy) && t < max_cyc) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_done", exp_rsp.size(), 0);
    endtask

    task automatic load_req(input int idx);
        req_valid  = 1'b1;
        req_write  = st_wr[idx];
        req_offset = st_off[idx];
        req_wdata  = st_wd[idx];
    endtask

    task automatic check_reset_state();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp", {rsp_valid, rsp_write, rsp_err}, '0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_strobe", {gpio_en, write_enable}, '0);
        check("rst_gpio_addr", gpio_addr, '0);
        check("rst_gpio_in", gpio_in, '0);
        check("rst_dir_shadow", dir_shadow, '0);
        check("rst_busy", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, r0, acc, t, k;
        logic [3:0] off;

        rst_n = 1'b0; mon_on = 1'b0; rand_rdy = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_offset = '0; req_wdata = '0;
        rsp_ready = 1'b1; pins = '0;
        for (int i = 0; i < 2; i++) begin
            ref_data[i] = '0; ref_dir[i] = '0; exp_dir[i] = '0;
        end
        st_wr[0] = 1'b0; st_off[0] = 4'h0; st_wd[0] = 32'h0;
        st_wr[1] = 1'b1; st_off[1] = 4'h4; st_wd[1] = 32'h1357_2468;
        st_wr[2] = 1'b0; st_off[2] = 4'h4; st_wd[2] = 32'h0;
        st_wr[3] = 1'b0; st_off[3] = 4'hE; st_wd[3] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        mon_on = 1'b1;

        // two writes: DIR then DATA
        n0 = n_stb; r0 = n_rsp;
        push(1'b1, 4'h4, 32'hAAAA_AAAA);
        push(1'b1, 4'h0, 32'hDEAD_BEEF);
        drain(100);
        check("t1_strobes", n_stb - n0, 2);
        check("t1_rsps", n_rsp - r0, 2);
        check("t1_dir", dir_shadow, 32'hAAAA_AAAA);

        // READ register through both latencies, back-to-back for throughput
        pins = 32'hCAFE_BABE;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            r0 = n_rsp;
            push(1'b0, 4'h8, 32'h0);
            push(1'b0, 4'h8, 32'h0);
            drain(100);
            check("t2_rsps", n_rsp - r0, 2);
            check("t2_read_gap", stb_cyc[$] - stb_cyc[$-1], (s == 1) ? 6 : 4);
        end

        // rejected requests: no strobe, 2-cycle throughput
        sel = 1'b0;
        n0 = n_stb; r0 = n_rsp;
        push(1'b0, 4'hC, 32'h0);
        push(1'b1, 4'h8, 32'h1234_5678);
        drain(100);
        check("t3_no_strobe", n_stb - n0, 0);
        check("t3_rsps", n_rsp - r0, 2);
        check("t3_err_gap", rsp_cyc[$] - rsp_cyc[$-1], 2);

        // response stall: FIFO fills behind a held response
        rsp_ready = 1'b0;
        r0 = n_rsp;
        push(1'b1, 4'h0, 32'h1111_1111);
        t = 0;
        while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
        check("t4_stalled", rsp_valid, 1'b1);
        acc = 0;
        load_req(0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t4_hold_valid", rsp_valid, 1'b1);
            check("t4_hold_fields", {rsp_write, rsp_err, rsp_rdata},
                  {exp_rsp[0].wr, exp_rsp[0].err, exp_rsp[0].data});
            if (req_ready) acc++;
            @(posedge clk); #1;
            if (acc < 4) load_req(acc); else req_valid = 1'b0;
        end
        check("t4_accepted", acc, 2);
        check("t4_ready_low", req_ready, 1'b0);
        rsp_ready = 1'b1;
        t = 0;
        while (acc < 4 && t < 100) begin
            @(negedge clk);
            if (req_ready) acc++;
            @(posedge clk); #1;
            if (acc < 4) load_req(acc); else req_valid = 1'b0;
            t++;
        end
        req_valid = 1'b0;
        check("t4_all_accepted", acc, 4);
        drain(200);
        check("t4_rsps", n_rsp - r0, 5);

        // back-to-back writes: strobes 3 cycles apart, busy held
        push(1'b1, 4'h4, 32'h5555_5555);
        push(1'b1, 4'h0, 32'hA5A5_A5A5);
        t = 0;
        while (exp_rsp.size() != 0 && t < 50) begin
            check("t5_busy", busy, 1'b1);
            @(posedge clk); #1;
            t++;
        end
        check("t5_busy_off", busy, 1'b0);
        check("t5_write_gap", stb_cyc[$] - stb_cyc[$-1], 3);
        check("t5_dir", dir_shadow, 32'h5555_5555);

        // asynchronous reset during the WAIT of a latency-3 read
        sel = 1'b1;
        push(1'b1, 4'h4, 32'h0F0F_0F0F);
        drain(100);
        check("t6_dir_pre", dir_shadow, 32'h0F0F_0F0F);
        pins = 32'h1357_9BDF;
        push(1'b0, 4'h8, 32'h0);
        t = 0;
        while (!gpio_en && t < 20) begin @(posedge clk); #1; t++; end
        check("t6_strobe_seen", gpio_en, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        mon_on = 1'b0;
        #1;
        check_reset_state();
        exp_stb.delete();
        exp_rsp.delete();
        exp_dir[0] = '0;
        exp_dir[1] = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        mon_on = 1'b1;
        r0 = n_rsp;
        repeat (6) begin
            @(negedge clk);
            check("t6_no_rsp", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        pins = 32'h2468_ACE0;
        push(1'b0, 4'h8, 32'h0);
        drain(100);
        check("t6_after_rsps", n_rsp - r0, 1);

        // randomized traffic on both instances with random response back-pressure
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            pins = $urandom();
            r0 = n_rsp;
            rand_rdy = 1'b1;
            for (int i = 0; i < 60; i++) begin
                k = $urandom_range(0, 3);
                off = (k == 0) ? 4'h0 : (k == 1) ? 4'h4 : (k == 2) ? 4'h8 : 4'($urandom_range(0, 15));
                push(1'($urandom_range(0, 1)), off, $urandom());
                k = $urandom_range(0, 2);
                repeat (k) begin @(posedge clk); #1; end
            end
            rand_rdy = 1'b0;
            @(posedge clk); #2;
            rsp_ready = 1'b1;
            drain(500);
            check("t7_rsps", n_rsp - r0, 60);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gpio_bus_master.md
Name: gpio_bus_master

Overview:
- Bus initiator for the GPIO register block; drives the gpio_en / write_enable / gpio_addr / gpio_in strobe interface that the GPIO IP responds to, and captures read data from gpio_out.
- Accepts queued register-access requests over a valid/ready port, serialises them into single-cycle bus strobes, and returns one valid/ready response per request.
- Sits between the CPU-side access logic and the GPIO IP. Register map (offsets from BASE_ADDR): DATA 0x0 (RW), DIR 0x4 (RW), READ 0x8 (RO).

Parameters:
- BASE_ADDR, 32'h2000_0000, base added to the request offset to form gpio_addr.
- RD_LATENCY, 1, cycles from the strobe cycle to valid gpio_out; legal range 1..7.
- FIFO_DEPTH, 2, request FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept a request; equals !full, from registered state only.
- req_write  in  1  1 = write, 0 = read.
- req_offset  in  4  byte offset into the register map.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echoes req_write of the completed request.
- rsp_err  out  1  request rejected without any bus access.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- gpio_en  out  1  bus strobe.
- write_enable  out  1  write qualifier; only asserted together with gpio_en.
- gpio_addr  out  32  register address.
- gpio_in  out  32  write data to the IP.
- gpio_out  in  32  read data from the IP.
- dir_shadow  out  32  copy of the last DIR value successfully written.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (asynchronous, active-low) takes effect immediately, mid-transaction included:
  - FIFO empties.
  - FSM goes to IDLE.
  - All outputs go to 0, including dir_shadow and busy; req_ready goes to 1.
  - An in-flight request is dropped and gets no response.
- All bus outputs and rsp_* outputs are registered. Outside the ISSUE state, gpio_en, write_enable, gpio_addr and gpio_in are 0.
- FIFO:
  - Push when req_valid && req_ready.
  - A push and a pop in the same cycle are both legal.
  - When full, req_ready stays 0 even if a pop occurs that cycle; there is no same-cycle refill.
  - Requests are handled strictly in order.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the FIFO is not empty, pop the head into the command registers.
  - If the offset is not 0x0, 0x4 or 0x8, or the request is a write to 0x8, go to RESP with err=1 and rdata=0. No strobe is issued.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle, cycle T):
  - gpio_en=1, write_enable=req_write, gpio_addr=BASE_ADDR+offset.
  - gpio_in=wdata for writes, 0 for reads.
  - On a write: go to RESP with rdata=0. A write to 0x4 updates dir_shadow on the same edge.
  - On a read: load a down-counter with RD_LATENCY and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the edge that ends cycle T+RD_LATENCY, capture gpio_out into rsp_rdata and go to RESP.
  - With RD_LATENCY=1, WAIT lasts one cycle and samples the value present during T+1.
- RESP:
  - rsp_valid=1, with rsp_write, rsp_err and rsp_rdata stable until rsp_ready is seen.
  - On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
  - Stalling on rsp_ready never drops a request; new requests keep filling the FIFO.
- Throughput with rsp_ready held at 1:
  - Write: 3 cycles (IDLE, ISSUE, RESP).
  - Read: 3+RD_LATENCY cycles.
  - Error: 2 cycles.
- Address arithmetic is a 32-bit add with wrap-around. gpio_en and write_enable never glitch high outside ISSUE.

Test Plan:
- Reset, then write DIR 0x4 = 0xAAAAAAAA, then write DATA 0x0 = 0xDEADBEEF -> one strobe each:
  - gpio_addr 0x20000004 then 0x20000000; write_enable=1; gpio_in matches.
  - dir_shadow = 0xAAAAAAAA.
  - Two responses with rsp_err=0 and rsp_rdata=0.
- Read 0x8 with the IP model returning 0xCAFEBABE one cycle after the strobe (RD_LATENCY=1) -> write_enable=0, gpio_in=0, rsp_rdata=0xCAFEBABE, rsp_write=0. Repeat with RD_LATENCY=3 and a delayed model; same data.
- Read offset 0xC, then write offset 0x8 = 0x12345678 -> gpio_en never asserts; two responses with rsp_err=1 and rsp_rdata=0.
- Hold rsp_ready=0 and push 4 back-to-back requests -> req_ready drops after 2 are accepted; the first response holds stable. Release rsp_ready -> all responses arrive in order and none are lost.
- Write DIR 0x55555555, then write DATA 0xA5A5A5A5 with rsp_ready=1 -> strobes 3 cycles apart; busy=1 throughout, then 0.
- Assert rst_n=0 during WAIT of a read -> outputs go to 0 immediately, no response is produced, dir_shadow=0, req_ready=1. A new read completes normally after reset.
